// File: rtl/pe_phase_sequencer_if.sv
// Handshake/control bundle between the training controller and pe_phase_sequencer.
// The stall_cnt field (and PERF_W) exist only when PE_SEQ_PERF_CNT_EN is defined.
interface pe_phase_sequencer_if #(
    parameter int CNT_W  = 8,
    parameter int ITER_W = 4
`ifdef PE_SEQ_PERF_CNT_EN
    , parameter int PERF_W = 16
`endif
);
    logic              start;
    logic              abort;
    logic              stride;
    logic              stall;
    logic [CNT_W-1:0]  fp_len;
    logic [CNT_W-1:0]  bp_len;
    logic [CNT_W-1:0]  wg_len;
    logic [ITER_W-1:0] iter_num;

    logic              busy;
    logic              done;
    logic [1:0]        phase;
    logic [ITER_W-1:0] iter_cnt;
    logic              in_en;
    logic              pe_rst;
    logic [3:0]        sel_m;
    logic [1:0]        sel;
`ifdef PE_SEQ_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cnt;
`endif

    modport master (
        output start, abort, stride, stall, fp_len, bp_len, wg_len, iter_num,
        input  busy, done, phase, iter_cnt, in_en, pe_rst, sel_m, sel
`ifdef PE_SEQ_PERF_CNT_EN
        , input stall_cnt
`endif
    );

    modport slave (
        input  start, abort, stride, stall, fp_len, bp_len, wg_len, iter_num,
        output busy, done, phase, iter_cnt, in_en, pe_rst, sel_m, sel
`ifdef PE_SEQ_PERF_CNT_EN
        , output stall_cnt
`endif
    );
endinterface

// File: rtl/pe_phase_sequencer.sv
// FP -> BP -> WG training-phase sequencer for the PE array, each executed phase followed by a
// pe_rst window. Optional stall counter enabled by defining PE_SEQ_PERF_CNT_EN.
module pe_phase_sequencer #(
    parameter int CNT_W      = 8,
    parameter int ITER_W     = 4,
    parameter int RST_CYCLES = 2,
    parameter int PERF_W     = 16
) (
    input  logic                  clk,
    input  logic                  fsm_rst_n,
    pe_phase_sequencer_if.slave   bus
);

    if (RST_CYCLES < 1 || RST_CYCLES > 15 || PERF_W < 1 || CNT_W < 4) begin : g_bad_params
        $error("pe_phase_sequencer: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FP_RUN,
        S_FP_RST,
        S_BP_RUN,
        S_BP_RST,
        S_WG_RUN,
        S_WG_RST
    } state_t;

    localparam logic [CNT_W-1:0] RstLast = CNT_W'(RST_CYCLES - 1);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ITER_W-1:0] iter_q;
    logic [CNT_W-1:0]  fp_len_q;
    logic [CNT_W-1:0]  bp_len_q;
    logic [CNT_W-1:0]  wg_len_q;
    logic [ITER_W-1:0] iter_num_q;
    logic              stride_q;
    logic              done_q;

    function automatic state_t first_phase(input logic fp_en, input logic bp_en,
                                           input logic wg_en);
        if (fp_en)      return S_FP_RUN;
        else if (bp_en) return S_BP_RUN;
        else if (wg_en) return S_WG_RUN;
        else            return S_IDLE;
    endfunction

    // S_IDLE return value means "end of this iteration", not "stop".
    function automatic state_t phase_after_rst(input state_t s, input logic bp_en,
                                               input logic wg_en);
        case (s)
            S_FP_RST: begin
                if (bp_en)      return S_BP_RUN;
                else if (wg_en) return S_WG_RUN;
                else            return S_IDLE;
            end
            S_BP_RST: return wg_en ? S_WG_RUN : S_IDLE;
            default:  return S_IDLE;
        endcase
    endfunction

    function automatic state_t rst_of_run(input state_t s);
        case (s)
            S_FP_RUN: return S_FP_RST;
            S_BP_RUN: return S_BP_RST;
            default:  return S_WG_RST;
        endcase
    endfunction

    logic [CNT_W-1:0] run_len_d;
    logic             is_run_d;
    logic             is_rst_d;
    logic             run_last_d;
    logic             iter_last_d;
    state_t           start_first_d;
    state_t           restart_first_d;
    state_t           after_rst_d;

    always_comb begin
        run_len_d = '0;
        is_run_d  = 1'b0;
        is_rst_d  = 1'b0;
        case (state_q)
            S_FP_RUN: begin run_len_d = fp_len_q; is_run_d = 1'b1; end
            S_BP_RUN: begin run_len_d = bp_len_q; is_run_d = 1'b1; end
            S_WG_RUN: begin run_len_d = wg_len_q; is_run_d = 1'b1; end
            S_FP_RST, S_BP_RST, S_WG_RST: is_rst_d = 1'b1;
            default: ;
        endcase
    end

    assign run_last_d  = (cnt_q == (run_len_d - CNT_W'(1)));
    // iter_num of 0 runs a single iteration, same as 1.
    assign iter_last_d = (iter_num_q == '0) ? (iter_q == '0)
                                            : (iter_q == (iter_num_q - ITER_W'(1)));
    assign start_first_d   = first_phase(bus.fp_len != '0, bus.bp_len != '0, bus.wg_len != '0);
    assign restart_first_d = first_phase(fp_len_q != '0, bp_len_q != '0, wg_len_q != '0);
    assign after_rst_d     = phase_after_rst(state_q, bp_len_q != '0, wg_len_q != '0);

    always_ff @(posedge clk or negedge fsm_rst_n) begin
        if (!fsm_rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            iter_q     <= '0;
            fp_len_q   <= '0;
            bp_len_q   <= '0;
            wg_len_q   <= '0;
            iter_num_q <= '0;
            stride_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.abort) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                iter_q  <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.start) begin
                            fp_len_q   <= bus.fp_len;
                            bp_len_q   <= bus.bp_len;
                            wg_len_q   <= bus.wg_len;
                            iter_num_q <= bus.iter_num;
                            stride_q   <= bus.stride;
                            iter_q     <= '0;
                            cnt_q      <= '0;
                            state_q    <= start_first_d;
                            // Nothing to execute: complete immediately without leaving IDLE.
                            done_q     <= (start_first_d == S_IDLE);
                        end
                    end
                    S_FP_RUN, S_BP_RUN, S_WG_RUN: begin
                        if (!bus.stall) begin
                            if (run_last_d) begin
                                cnt_q   <= '0;
                                state_q <= rst_of_run(state_q);
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    S_FP_RST, S_BP_RST, S_WG_RST: begin
                        if (cnt_q == RstLast) begin
                            cnt_q <= '0;
                            if (after_rst_d != S_IDLE) begin
                                state_q <= after_rst_d;
                            end else if (iter_last_d) begin
                                state_q <= S_IDLE;
                                done_q  <= 1'b1;
                            end else begin
                                iter_q  <= iter_q + ITER_W'(1);
                                state_q <= restart_first_d;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    logic [1:0] phase_d;
    logic [3:0] sel_m_d;
    logic [1:0] sel_d;

    // Selects follow the phase through both its RUN and RST windows.
    always_comb begin
        phase_d = 2'd0;
        sel_m_d = 4'b0000;
        sel_d   = 2'b00;
        case (state_q)
            S_FP_RUN, S_FP_RST: begin
                phase_d = 2'd1;
                sel_m_d = {2'b00, stride_q, stride_q};
                sel_d   = 2'b10;
            end
            S_BP_RUN, S_BP_RST: begin
                phase_d = 2'd2;
                sel_d   = {!stride_q, 1'b0};
            end
            S_WG_RUN, S_WG_RST: begin
                phase_d = 2'd3;
                sel_m_d = {2'b11, stride_q, stride_q};
                sel_d   = 2'b01;
            end
            default: ;
        endcase
    end

    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;
    assign bus.phase    = phase_d;
    assign bus.iter_cnt = iter_q;
    assign bus.in_en    = is_run_d && !bus.stall;
    assign bus.pe_rst   = is_rst_d;
    assign bus.sel_m    = sel_m_d;
    assign bus.sel      = sel_d;

`ifdef PE_SEQ_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cnt_q;

    // Not cleared by abort, so the count of an aborted run stays readable in IDLE.
    always_ff @(posedge clk or negedge fsm_rst_n) begin
        if (!fsm_rst_n) begin
            stall_cnt_q <= '0;
        end else if ((state_q == S_IDLE) && bus.start && !bus.abort) begin
            stall_cnt_q <= '0;
        end else if (is_run_d && bus.stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + PERF_W'(1);
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pe_phase_sequencer.sv
// Self-checking bench for pe_phase_sequencer: phase-list reference model compared every cycle,
// directed scenarios with hand-computed expectations, then randomized runs.
module tb_pe_phase_sequencer;
    localparam int CNT_W      = 8;
    localparam int ITER_W     = 4;
    localparam int RST_CYCLES = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pe_phase_sequencer_if #(.CNT_W(CNT_W), .ITER_W(ITER_W)
`ifdef PE_SEQ_PERF_CNT_EN
        , .PERF_W(16)
`endif
    ) bus ();

    pe_phase_sequencer #(.CNT_W(CNT_W), .ITER_W(ITER_W), .RST_CYCLES(RST_CYCLES), .PERF_W(16))
        u_dut (.clk(clk), .fsm_rst_n(rst_n), .bus(bus));

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- reference model: list of executed phases per iteration ----------------
    bit m_active, m_in_rst, m_done, m_stride;
    int m_plist[$];
    int m_pos, m_cnt, m_rcnt, m_iter, m_iters, m_stall_cnt;
    int m_len[4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_in_rst = 0; m_done = 0; m_stride = 0;
            m_pos = 0; m_cnt = 0; m_rcnt = 0; m_iter = 0; m_iters = 1; m_stall_cnt = 0;
            m_plist.delete();
        end else begin
            if (m_active && !m_in_rst && bus.stall && m_stall_cnt < 65535) m_stall_cnt++;
            m_done = 0;
            if (bus.abort) begin
                m_active = 0;
                m_iter = 0;
            end else if (!m_active) begin
                if (bus.start) begin
                    m_len[1] = int'(bus.fp_len);
                    m_len[2] = int'(bus.bp_len);
                    m_len[3] = int'(bus.wg_len);
                    m_stride = bus.stride;
                    m_iters = (bus.iter_num == 0) ? 1 : int'(bus.iter_num);
                    m_iter = 0;
                    m_stall_cnt = 0;
                    m_plist.delete();
                    for (int p = 1; p <= 3; p++) if (m_len[p] != 0) m_plist.push_back(p);
                    if (m_plist.size() == 0) m_done = 1;
                    else begin m_active = 1; m_pos = 0; m_in_rst = 0; m_cnt = 0; end
                end
            end else if (!m_in_rst) begin
                if (!bus.stall) begin
                    m_cnt++;
                    if (m_cnt == m_len[m_plist[m_pos]]) begin m_in_rst = 1; m_rcnt = 0; end
                end
            end else begin
                m_rcnt++;
                if (m_rcnt == RST_CYCLES) begin
                    m_in_rst = 0;
                    m_cnt = 0;
                    m_pos++;
                    if (m_pos == m_plist.size()) begin
                        m_pos = 0;
                        if (m_iter == m_iters - 1) begin m_active = 0; m_done = 1; end
                        else m_iter++;
                    end
                end
            end
        end
    end

    // ---------------- compare process + measurement counters ----------------
    int cyc = 0, rise_cyc = 0, done_cyc = 0;
    int tot_busy = 0, tot_inen = 0, tot_perst = 0, tot_done = 0, tot_ph2 = 0, tot_iter2 = 0;
    int tot_fprun = 0, done_stall = 0;
    logic prev_busy = 1'b0;
    logic [3:0] obs_selm [4];
    logic [1:0] obs_sel [4];
    int e_ph;
    logic [3:0] e_selm;
    logic [1:0] e_sel;
    logic [15:0] e_vec, a_vec;

    always @(negedge clk) begin
        e_ph = m_active ? m_plist[m_pos] : 0;
        e_selm = 4'b0000;
        e_sel = 2'b00;
        case (e_ph)
            1: begin e_selm = {2'b00, m_stride, m_stride}; e_sel = 2'b10; end
            2: begin e_selm = 4'b0000; e_sel = {!m_stride, 1'b0}; end
            3: begin e_selm = {2'b11, m_stride, m_stride}; e_sel = 2'b01; end
            default: ;
        endcase
        e_vec = {m_active, m_done, 2'(e_ph), 4'(m_iter), m_active && !m_in_rst && !bus.stall,
                 m_active && m_in_rst, e_selm, e_sel};
        a_vec = {bus.busy, bus.done, bus.phase, bus.iter_cnt, bus.in_en, bus.pe_rst,
                 bus.sel_m, bus.sel};
        chk("outputs{busy,done,phase,iter,in_en,pe_rst,sel_m,sel}", 32'(a_vec), 32'(e_vec));
`ifdef PE_SEQ_PERF_CNT_EN
        chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall_cnt));
`endif
        cyc++;
        if (bus.busy && !prev_busy) rise_cyc = cyc;
        prev_busy = bus.busy;
        if (bus.busy) tot_busy++;
        if (bus.in_en) tot_inen++;
        if (bus.pe_rst) tot_perst++;
        if (bus.busy && bus.phase == 2'd2) tot_ph2++;
        if (bus.busy && bus.iter_cnt == 4'd2) tot_iter2++;
        if (bus.busy && bus.phase == 2'd1 && !bus.pe_rst) tot_fprun++;
        if (bus.busy) begin
            obs_selm[bus.phase] = bus.sel_m;
            obs_sel[bus.phase] = bus.sel;
        end
        if (bus.done) begin
            tot_done++;
            done_cyc = cyc;
`ifdef PE_SEQ_PERF_CNT_EN
            done_stall = int'(bus.stall_cnt);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_run(input int fp, input int bp, input int wg, input int it, input bit st);
        bus.fp_len = CNT_W'(fp);
        bus.bp_len = CNT_W'(bp);
        bus.wg_len = CNT_W'(wg);
        bus.iter_num = ITER_W'(it);
        bus.stride = st;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int bound);
        int n;
        n = 0;
        while (m_active && n < bound) begin tick(); n++; end
        chk(nm, 32'(m_active), 32'd0);
        tick();
        tick();
    endtask

    task automatic wait_phase(input string nm, input logic [1:0] ph, input int bound);
        int n;
        n = 0;
        while (!(bus.phase == ph && !bus.pe_rst) && n < bound) begin tick(); n++; end
        chk(nm, 32'(bus.phase), 32'(ph));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int b0, i0, r0, d0, p0, t0, f0;

    initial begin
        bus.start = 0; bus.abort = 0; bus.stall = 0;
        set_run(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({bus.busy, bus.done, bus.phase, bus.iter_cnt, bus.in_en,
                                  bus.pe_rst, bus.sel_m, bus.sel}), 32'd0);
        rst_n = 1'b1;
        tick();

        // basic run, stride 0
        set_run(6, 6, 6, 1, 0);
        b0 = tot_busy; i0 = tot_inen; r0 = tot_perst; d0 = tot_done;
        pulse_start();
        wait_idle("basic_finish", 200);
        chk("basic_busy_cycles", 32'(tot_busy - b0), 32'd24);
        chk("basic_in_en_cycles", 32'(tot_inen - i0), 32'd18);
        chk("basic_pe_rst_cycles", 32'(tot_perst - r0), 32'd6);
        chk("basic_done_count", 32'(tot_done - d0), 32'd1);
        chk("basic_done_latency", 32'(done_cyc - rise_cyc), 32'd24);
        chk("fp_sel_s0", 32'(obs_sel[1]), 32'b10);
        chk("bp_sel_s0", 32'(obs_sel[2]), 32'b10);
        chk("wg_sel_m_s0", 32'(obs_selm[3]), 32'b1100);

        // stride 1 selects
        set_run(6, 6, 6, 1, 1);
        pulse_start();
        wait_idle("stride_finish", 200);
        chk("fp_sel_m_s1", 32'(obs_selm[1]), 32'b0011);
        chk("fp_sel_s1", 32'(obs_sel[1]), 32'b10);
        chk("bp_sel_m_s1", 32'(obs_selm[2]), 32'b0000);
        chk("bp_sel_s1", 32'(obs_sel[2]), 32'b00);
        chk("wg_sel_m_s1", 32'(obs_selm[3]), 32'b1111);
        chk("wg_sel_s1", 32'(obs_sel[3]), 32'b01);

        // stall for 3 cycles mid-FP
        set_run(4, 0, 0, 1, 0);
        b0 = tot_busy; i0 = tot_inen; f0 = tot_fprun; d0 = tot_done;
        pulse_start();
        tick();
        tick();
        bus.stall = 1'b1;
        repeat (3) tick();
        bus.stall = 1'b0;
        wait_idle("stall_finish", 100);
        chk("stall_fp_run_cycles", 32'(tot_fprun - f0), 32'd7);
        chk("stall_in_en_cycles", 32'(tot_inen - i0), 32'd4);
        chk("stall_busy_cycles", 32'(tot_busy - b0), 32'd9);
        chk("stall_done_count", 32'(tot_done - d0), 32'd1);
`ifdef PE_SEQ_PERF_CNT_EN
        chk("stall_cnt_at_done", 32'(done_stall), 32'd3);
`endif

        // BP skipped, three iterations
        set_run(3, 0, 3, 3, 0);
        b0 = tot_busy; p0 = tot_ph2; t0 = tot_iter2; d0 = tot_done;
        pulse_start();
        wait_idle("skip_finish", 200);
        chk("skip_busy_cycles", 32'(tot_busy - b0), 32'd30);
        chk("skip_phase2_cycles", 32'(tot_ph2 - p0), 32'd0);
        chk("skip_iter2_cycles", 32'(tot_iter2 - t0), 32'd10);
        chk("skip_done_count", 32'(tot_done - d0), 32'd1);

        // iter_num 0 behaves as 1
        set_run(3, 0, 3, 0, 0);
        b0 = tot_busy;
        pulse_start();
        wait_idle("iter0_finish", 200);
        chk("iter0_busy_cycles", 32'(tot_busy - b0), 32'd10);

        // abort during BP_RUN, then a clean run
        set_run(6, 6, 6, 1, 0);
        d0 = tot_done;
        pulse_start();
        wait_phase("abort_reach_bp", 2'd2, 50);
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_phase", 32'(bus.phase), 32'd0);
        repeat (3) tick();
        chk("abort_no_done", 32'(tot_done - d0), 32'd0);
        b0 = tot_busy; d0 = tot_done;
        pulse_start();
        wait_idle("post_abort_finish", 200);
        chk("post_abort_busy_cycles", 32'(tot_busy - b0), 32'd24);
        chk("post_abort_done_count", 32'(tot_done - d0), 32'd1);

        // asynchronous reset in the middle of WG
        pulse_start();
        wait_phase("areset_reach_wg", 2'd3, 80);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("areset_outputs", 32'({bus.busy, bus.done, bus.phase, bus.iter_cnt, bus.in_en,
                                   bus.pe_rst, bus.sel_m, bus.sel}), 32'd0);
`ifdef PE_SEQ_PERF_CNT_EN
        chk("areset_stall_cnt", 32'(bus.stall_cnt), 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        tick();

        // all lengths zero
        set_run(0, 0, 0, 2, 0);
        b0 = tot_busy; d0 = tot_done;
        pulse_start();
        tick();
        tick();
        chk("zero_done_count", 32'(tot_done - d0), 32'd1);
        chk("zero_busy_cycles", 32'(tot_busy - b0), 32'd0);

        // start held high through part of a run
        set_run(6, 6, 6, 1, 0);
        b0 = tot_busy; d0 = tot_done;
        bus.start = 1'b1;
        repeat (10) tick();
        bus.start = 1'b0;
        wait_idle("held_start_finish", 200);
        chk("held_start_busy_cycles", 32'(tot_busy - b0), 32'd24);
        chk("held_start_done_count", 32'(tot_done - d0), 32'd1);

        // start and abort together in IDLE
        b0 = tot_busy; d0 = tot_done;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        tick();
        tick();
        chk("start_abort_busy", 32'(tot_busy - b0), 32'd0);
        chk("start_abort_done", 32'(tot_done - d0), 32'd0);

        // randomized runs, per-cycle model comparison
        for (int r = 0; r < 60; r++) begin
            int n;
            set_run(($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 7)),
                    ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 7)),
                    ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 7)),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            bus.start = 1'b1;
            tick();
            n = 0;
            while (n < 1500) begin
                bus.start = ($urandom_range(0, 19) == 0);
                bus.stall = ($urandom_range(0, 3) == 0);
                bus.abort = ($urandom_range(0, 149) == 0);
                bus.fp_len = CNT_W'($urandom_range(0, 255));
                bus.bp_len = CNT_W'($urandom_range(0, 255));
                bus.wg_len = CNT_W'($urandom_range(0, 255));
                bus.iter_num = ITER_W'($urandom_range(0, 15));
                bus.stride = 1'($urandom_range(0, 1));
                tick();
                n++;
                if (!m_active && n >= 4) break;
            end
            bus.start = 1'b0;
            bus.stall = 1'b0;
            bus.abort = 1'b0;
            chk("rand_run_ends", 32'(m_active), 32'd0);
            repeat (2) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pe_phase_sequencer.md
Name: pe_phase_sequencer

Overview:
- Parametrised training-phase sequencer for the PE array.
- Runs forward pass (FP), backward pass (BP) and weight gradient (WG), each followed by a PE reset window.
- Per-phase lengths and iteration count are run-time inputs. Supports stall, abort, phase skipping and a start/busy/done handshake.
- Drives the PE mux selects, in_en and pe_rst.

Parameters:
- CNT_W, 8, width of per-phase length inputs and the phase cycle counter
- ITER_W, 4, width of iteration count input and iteration counter
- RST_CYCLES, 2, cycles pe_rst is held after each executed phase (legal range 1..15)
- PERF_W, 16, width of the optional stall counter

Ports:
- clk  in  1  clock, rising edge
- fsm_rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a run; sampled only in IDLE
- abort  in  1  synchronous abort, any state
- stride  in  1  stride mode (0 = stride 1, 1 = stride 2)
- fp_len  in  CNT_W  FP enabled cycles; 0 skips FP
- bp_len  in  CNT_W  BP enabled cycles; 0 skips BP
- wg_len  in  CNT_W  WG enabled cycles; 0 skips WG
- iter_num  in  ITER_W  FP/BP/WG iterations; 0 treated as 1
- stall  in  1  freeze the compute counter during RUN states
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on normal completion
- phase  out  2  0 = idle, 1 = FP, 2 = BP, 3 = WG; held through that phase's reset window
- iter_cnt  out  ITER_W  current iteration index, 0-based
- in_en  out  1  PE input enable
- pe_rst  out  1  active-high PE reset
- sel_m  out  4  {select_m3, select_m2, select_m1, select_m0}
- sel  out  2  {select1, select0}

Behaviour:
- Reset (fsm_rst_n low) is asynchronous. It forces state IDLE; all counters, shadow registers and outputs go to 0.
- States: IDLE, FP_RUN, FP_RST, BP_RUN, BP_RST, WG_RUN, WG_RST.
- Outputs are decoded from registered state and counters. done is a registered output.
- start in IDLE:
  - Latches stride, lengths and iter_num into shadow registers.
  - Clears iter_cnt.
  - Next state is the first phase with non-zero length.
  - start while busy is ignored. Inputs changing mid-run have no effect.
- All lengths zero: start goes IDLE -> IDLE with done=1 on the next cycle; busy never rises.
- X_RUN:
  - in_en = !stall.
  - Counter increments only when !stall.
  - Exit to X_RST in the cycle where counter == len-1 and !stall, giving exactly len enabled cycles.
  - Counter clears on exit.
- X_RST:
  - pe_rst=1 and in_en=0 for exactly RST_CYCLES cycles. stall is ignored.
  - Then go to the next non-skipped phase in FP -> BP -> WG order.
- Iteration end (after the last executed phase's RST):
  - If iter_cnt == max(iter_num,1)-1: go to IDLE and pulse done=1 for one cycle.
  - Otherwise increment iter_cnt and go to the first non-skipped phase.
- Mux selects, held through the RUN and RST of each phase:
  - IDLE: sel_m=0, sel=0.
  - FP: select_m0=select_m1=stride, select_m2=select_m3=0, select0=0, select1=1.
  - BP: sel_m=0, select0=0, select1=!stride.
  - WG: select_m0=select_m1=stride, select_m2=select_m3=1, select0=1, select1=0.
- abort:
  - Next state is IDLE from any state; no done pulse.
  - Counters clear. All outputs take their reset values next cycle.
  - abort has priority over start and over any transition.
- stall in IDLE or RST states has no effect.
- Counters wrap only by explicit clear; there is no overflow path because len <= 2^CNT_W-1.

Optional Feature:
- Macro: PE_SEQ_PERF_CNT_EN.
- Defined:
  - Adds output stall_cnt [PERF_W] counting cycles in any RUN state with stall=1.
  - Cleared on an accepted start and on reset; saturates at all-ones.
  - Held in IDLE, including after abort.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Basic run: fp/bp/wg_len=6, iter_num=1, RST_CYCLES=2, stride=0, start pulse.
  - FP in_en for 6 cycles with sel=2'b10, then pe_rst for 2 cycles.
  - Then BP and WG in the same pattern.
  - done pulses once, 24 cycles after the first FP cycle. busy falls with done.
- Stride and selects: stride=1, same run. FP sel_m=4'b0011, sel=2'b10; BP sel_m=0, sel=2'b00; WG sel_m=4'b1111, sel=2'b01.
- Stall: fp_len=4, stall high for 3 cycles mid-FP. FP_RUN lasts 7 cycles with in_en low exactly 3 cycles. With PE_SEQ_PERF_CNT_EN, stall_cnt=3 at done.
- Skip and iterations: bp_len=0, fp_len=wg_len=3, iter_num=3.
  - phase never equals 2. iter_cnt steps 0,1,2.
  - done after 3×(3+2+3+2)=30 cycles. iter_num=0 behaves as 1.
- Abort and reset: abort during BP_RUN gives IDLE next cycle, busy=0, no done. A later start runs cleanly. fsm_rst_n low mid-WG clears all outputs immediately (asynchronous).
- Edge cases:
  - All lengths 0 with start: done next cycle, busy stays 0.
  - start held high during a run: no restart.
  - start and abort together in IDLE: stays IDLE.
